sm4_key_expander: RTL
=====================

SM4_KEY_EXPANDER -- requirements
Module: sm4_key_expander

Interface
REQ-001 SHALL have parameter word_width_p, default 32, round-key word width.
REQ-002 SHALL have parameter key_size_p, default 128, master-key width.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port v_i  input  1  master key valid.
REQ-006 SHALL have port key_i  input  key_size_p  master key MK, MK0 in bits [127:96].
REQ-007 SHALL have port ready_o  output  1  block idle, will accept a key.
REQ-008 SHALL have port v_o  output  1  rk_o valid.
REQ-009 SHALL have port rk_o  output  word_width_p  current round key.
REQ-010 SHALL have port rk_idx_o  output  5  round index of rk_o (0..31).
REQ-011 SHALL have port ready_i  input  1  consumer (round datapath) accepts rk_o.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and (with the macro) FILL, DRAIN.
REQ-013 SHALL assert ready_o only in IDLE; a key is accepted on v_i & ready_o.
REQ-014 SHALL load K0..K3 = MK0..MK3 XOR FK0..FK3 (A3B1BAC6, 56AA3350, 677D9197, B27022DC) on acceptance and enter RUN.
REQ-015 SHALL compute in RUN K(i+4) = K(i) ^ L'(tau(K(i+1)^K(i+2)^K(i+3)^CK(i))), L'(B) = B ^ (B<<<13) ^ (B<<<23).
REQ-016 SHALL derive CK(i) byte j = (4i+j)*7 mod 256 from a 32-entry constant table.
REQ-017 SHALL present rk_o = K(i+4), rk_idx_o = i, v_o = 1 in the cycle after acceptance (latency 1), one key per cycle thereafter.
REQ-018 SHALL hold rk_o, rk_idx_o, the window K and the counter while v_o & ~ready_i.
REQ-019 SHALL advance the window and counter only on v_o & ready_i.
REQ-020 SHALL return to IDLE on handshake of index 31; ready_o rises the next cycle.
REQ-021 SHALL ignore v_i outside IDLE; key_i is sampled only at acceptance.

Reset
REQ-022 SHALL on reset_i force IDLE, counter 0, K window 0, ready_o=1, v_o=0, rk_o=0, rk_idx_o=0.
REQ-023 SHALL discard an in-flight expansion on reset mid-operation; no further v_o until a new key.
REQ-024 SHALL let reset_i override a simultaneous v_i handshake.

Configuration
REQ-025 SHALL, with SM4_KEY_DECRYPT_EN defined, add input port decrypt_i (1 bit), sampled at acceptance.
REQ-026 SHALL, with the macro and decrypt_i=1, enter FILL: compute rk0..rk31 into a 32x32 buffer at one per cycle with v_o=0, then enter DRAIN.
REQ-027 SHALL in DRAIN emit rk31..rk0 with rk_idx_o = 31..0 under the REQ-018/019 handshake, then return to IDLE.
REQ-028 SHALL, with the macro and decrypt_i=0, behave exactly as REQ-017..020.
REQ-029 SHALL, without the macro, omit decrypt_i, the buffer, FILL and DRAIN.

Structure
REQ-030 SHALL place FK constants, the CK table, the state enum and word_width_p/key_size_p in package sm4_encryptor.
REQ-031 SHALL instantiate one combinational sub-module sm4_sbox (8-bit in/out); tau uses four instances, which the round datapath reuses.

Verification
REQ-032 SHALL check: MK=0123456789ABCDEFFEDCBA9876543210, ready_i=1 -> rk0=F12186F9 one cycle after accept, rk1=41662B61, rk31=9124A012, ready_o high 33 cycles after accept.
REQ-033 SHALL check: same MK, ready_i low for 5 cycles at idx 7 -> rk_o/rk_idx_o stable, sequence matches REQ-032 vectors.
REQ-034 SHALL check: reset_i pulsed at idx 12 -> v_o=0 next cycle, ready_o=1; new key then expands from idx 0 correctly.
REQ-035 SHALL check: v_i held high in RUN with a different key -> ignored, all 32 keys from the first key.
REQ-036 SHALL check (macro on): decrypt_i=1, same MK -> v_o=0 for 32 cycles, then first output 9124A012 at idx 31, last F12186F9 at idx 0.
REQ-037 SHALL check: two back-to-back keys -> second accepted the cycle ready_o rises, no lost or duplicated index.

Source files
------------

// File: rtl/sm4_encryptor_pkg.sv
// Shared SM4 key-schedule constants (FK, CK), state encoding and the L' linear transform.
// Latency: none, constants and pure functions only.
// Backpressure: not applicable. FILL/DRAIN states exist only with SM4_KEY_DECRYPT_EN.
package sm4_encryptor;

    localparam int word_width_p = 32;
    localparam int key_size_p   = 128;

    localparam logic [0:3][31:0] fk_tbl = {
        32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc
    };

    // CK(i) byte j = (4i+j)*7 mod 256, MSB first
    localparam logic [0:31][31:0] ck_tbl = {
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

`ifdef SM4_KEY_DECRYPT_EN
    typedef enum logic [1:0] {IDLE, RUN, FILL, DRAIN} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    function automatic logic [31:0] l_prime(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_sbox.sv
// SM4 byte substitution, purely combinational lookup.
// Latency: 0 cycles.
// Backpressure: none.
module sm4_sbox (
    input  logic [7:0] x_dat,
    output logic [7:0] y_dat
);

    localparam logic [0:255][7:0] sbox_tbl = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    assign y_dat = sbox_tbl[x_dat];

endmodule

// File: rtl/sm4_key_expander.sv
// SM4 round-key expander streaming rk0..rk31 (SM4_KEY_DECRYPT_EN adds decrypt_i: buffer, replay rk31..rk0).
// Latency: first round key the cycle after key acceptance, then one per handshake (decrypt: after 32 fill cycles).
// Backpressure: v_o & ~ready_i freezes rk_o, rk_idx_o, key window and counter; ready_o high only in IDLE.
module sm4_key_expander #(
    parameter int word_width_p = sm4_encryptor::word_width_p,
    parameter int key_size_p   = sm4_encryptor::key_size_p
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic [key_size_p-1:0]   key_i,
`ifdef SM4_KEY_DECRYPT_EN
    input  logic                    decrypt_i,
`endif
    output logic                    ready_o,
    output logic                    v_o,
    output logic [word_width_p-1:0] rk_o,
    output logic [4:0]              rk_idx_o,
    input  logic                    ready_i
);
    import sm4_encryptor::*;

    state_t                  state_q, state_d;
    logic [word_width_p-1:0] k_q [4];
    logic [4:0]              cnt_q;
    logic [word_width_p-1:0] t_in, t_sub, k_next;
    logic                    load, shift;
`ifdef SM4_KEY_DECRYPT_EN
    logic [word_width_p-1:0] buf_q [32];
    logic                    bump;
`endif

    // tau: four byte-wide S-boxes over K(i+1)^K(i+2)^K(i+3)^CK(i)
    assign t_in = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck_tbl[cnt_q];
    for (genvar g = 0; g < 4; g++) begin : g_tau
        sm4_sbox u_sbox (.x_dat(t_in[8*g +: 8]), .y_dat(t_sub[8*g +: 8]));
    end
    assign k_next = k_q[0] ^ l_prime(t_sub);

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ready_o  = 1'b0;
        v_o      = 1'b0;
        rk_o     = '0;
        rk_idx_o = '0;
        load     = 1'b0;
        shift    = 1'b0;
`ifdef SM4_KEY_DECRYPT_EN
        bump     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) begin
                    load    = 1'b1;
`ifdef SM4_KEY_DECRYPT_EN
                    state_d = decrypt_i ? FILL : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                v_o      = 1'b1;
                rk_o     = k_next;
                rk_idx_o = cnt_q;
                if (ready_i) begin
                    shift = 1'b1;
                    if (cnt_q == 5'd31) state_d = IDLE;
                end
            end
`ifdef SM4_KEY_DECRYPT_EN
            FILL: begin
                shift = 1'b1;
                if (cnt_q == 5'd31) state_d = DRAIN;
            end
            // counter runs up again; ~cnt_q walks the buffer from 31 down to 0
            DRAIN: begin
                v_o      = 1'b1;
                rk_o     = buf_q[~cnt_q];
                rk_idx_o = ~cnt_q;
                if (ready_i) begin
                    bump = 1'b1;
                    if (cnt_q == 5'd31) state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            for (int i = 0; i < 4; i++) k_q[i] <= '0;
        end else if (load) begin
            cnt_q <= '0;
            for (int i = 0; i < 4; i++)
                k_q[i] <= key_i[key_size_p-1-word_width_p*i -: word_width_p] ^ fk_tbl[i];
        end else if (shift) begin
            cnt_q  <= cnt_q + 5'd1;
            k_q[0] <= k_q[1];
            k_q[1] <= k_q[2];
            k_q[2] <= k_q[3];
            k_q[3] <= k_next;
        end
`ifdef SM4_KEY_DECRYPT_EN
        else if (bump) begin
            cnt_q <= cnt_q + 5'd1;
        end
`endif
    end

`ifdef SM4_KEY_DECRYPT_EN
    always_ff @(posedge clk_i) begin
        if (state_q == FILL) buf_q[cnt_q] <= k_next;
    end
`endif

endmodule
